// File: rtl/ahb_cmd_master.sv
// AHB-Lite single-transfer master: valid/ready commands in, pipelined NONSEQ/SINGLE
// transfers out, in-order responses returned through a credit-limited FIFO.
module ahb_cmd_master #(
   parameter int ADDR_W    = 31,
   parameter int DATA_W    = 32,
   parameter int RSP_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [2:0]        cmd_size,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_error,
   output logic              hmastlock,
   output logic [1:0]        htrans,
   output logic [2:0]        hsize,
   output logic [2:0]        hburst,
   output logic              hwrite,
   output logic [3:0]        hprot,
   output logic [ADDR_W-1:0] haddr,
   output logic [DATA_W-1:0] hwdata,
   input  logic              hready,
   input  logic              hresp,
   input  logic [DATA_W-1:0] hrdata
);

   localparam int MAX_SIZE = $clog2(DATA_W / 8);
   localparam int PTR_W    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W    = $clog2(RSP_DEPTH + 4);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic {
      BUS_RUN,
      BUS_CANCEL
   } bus_state_e;

   bus_state_e        state_q, state_d;

   logic              apValid_q;
   logic [ADDR_W-1:0] apAddr_q;
   logic [2:0]        apSize_q;
   logic              apWrite_q;
   logic [DATA_W-1:0] apWdata_q;

   logic              dpValid_q;
   logic              dpWrite_q;
   logic [DATA_W-1:0] hwdata_q;

   logic              rejPend_q;

   logic [DATA_W-1:0] fifoRdata_q [RSP_DEPTH];
   logic              fifoError_q [RSP_DEPTH];
   logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
   logic [CNT_W-1:0]  fifoCnt_q;

   logic              err1, apMove, dpDone;
   logic              sizeIllegal, misaligned, cmdLegal;
   logic [ADDR_W-1:0] alignMask;
   logic [CNT_W-1:0]  creditUsed;
   logic              creditOk, baseReady;
   logic              cmdAccept, loadAp, reject;
   logic              push, pop;
   logic [DATA_W-1:0] pushRdata;
   logic              pushError;

   function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign err1   = dpValid_q & hresp & ~hready;
   assign apMove = apValid_q & hready & ~hresp & (state_q == BUS_RUN);
   assign dpDone = dpValid_q & hready;

   assign sizeIllegal = cmd_size > 3'(MAX_SIZE);
   assign alignMask   = ~({ADDR_W{1'b1}} << cmd_size);
   assign misaligned  = |(cmd_addr & alignMask);
   assign cmdLegal    = ~sizeIllegal & ~misaligned;

   // Every slot holding a command still owes one FIFO entry, so they all consume credit.
   assign creditUsed = CNT_W'(apValid_q) + CNT_W'(dpValid_q) + CNT_W'(rejPend_q) + fifoCnt_q;
   assign creditOk   = creditUsed < CNT_W'(RSP_DEPTH);
   assign baseReady  = reset & creditOk & (~apValid_q | apMove) & ~err1;
   assign cmd_ready  = baseReady & (cmdLegal | (~apValid_q & ~dpValid_q));

   assign cmdAccept = cmd_valid & cmd_ready;
   assign loadAp    = cmdAccept & cmdLegal;
   assign reject    = cmdAccept & ~cmdLegal;

   assign push      = dpDone | rejPend_q;
   assign pop       = rsp_valid & rsp_ready;
   assign pushRdata = (rejPend_q | dpWrite_q | hresp) ? '0 : hrdata;
   assign pushError = rejPend_q | hresp;

   // Bus-side control: cancel the pending address phase across a two-cycle ERROR.
   always_comb begin
      state_d = state_q;
      htrans  = HTRANS_IDLE;
      case (state_q)
         BUS_RUN: begin
            if (apValid_q) begin
               htrans = HTRANS_NONSEQ;
            end
            if (err1 && apValid_q) begin
               state_d = BUS_CANCEL;
            end
         end
         BUS_CANCEL: begin
            if (hready) begin
               state_d = BUS_RUN;
            end
         end
         default: state_d = BUS_RUN;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= BUS_RUN;
         apValid_q <= 1'b0;
         apAddr_q  <= '0;
         apSize_q  <= '0;
         apWrite_q <= 1'b0;
         apWdata_q <= '0;
         dpValid_q <= 1'b0;
         dpWrite_q <= 1'b0;
         hwdata_q  <= '0;
         rejPend_q <= 1'b0;
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         fifoCnt_q <= '0;
      end else begin
         state_q <= state_d;

         if (loadAp) begin
            apValid_q <= 1'b1;
            apAddr_q  <= cmd_addr;
            apSize_q  <= cmd_size;
            apWrite_q <= cmd_write;
            apWdata_q <= cmd_wdata;
         end else if (apMove) begin
            apValid_q <= 1'b0;
         end

         if (apMove) begin
            dpValid_q <= 1'b1;
            dpWrite_q <= apWrite_q;
            hwdata_q  <= apWdata_q;
         end else if (dpDone) begin
            dpValid_q <= 1'b0;
         end

         rejPend_q <= reject;

         if (push) begin
            wrPtr_q <= ptrInc(wrPtr_q);
         end
         if (pop) begin
            rdPtr_q <= ptrInc(rdPtr_q);
         end
         fifoCnt_q <= fifoCnt_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Storage needs no reset: the count alone decides what is visible.
   always_ff @(posedge clock) begin
      if (push) begin
         fifoRdata_q[wrPtr_q] <= pushRdata;
         fifoError_q[wrPtr_q] <= pushError;
      end
   end

   assert property (@(posedge clock) disable iff (!reset)
                    !(push && !pop && (fifoCnt_q == CNT_W'(RSP_DEPTH))));

   assign rsp_valid = (fifoCnt_q != '0);
   assign rsp_rdata = fifoRdata_q[rdPtr_q];
   assign rsp_error = fifoError_q[rdPtr_q];

   assign hmastlock = 1'b0;
   assign hburst    = 3'b000;
   assign hprot     = 4'b0011;
   assign haddr     = apAddr_q;
   assign hsize     = apSize_q;
   assign hwrite    = apWrite_q;
   assign hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench for ahb_cmd_master: the bench itself plays the AHB slave,
// cycle by cycle, with hand-computed expectations.
module tb_ahb_cmd_master;

   logic        clock = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [2:0]  cmd_size;
   logic [30:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_error;
   logic [31:0] rsp_rdata;
   logic        hmastlock, hwrite, hready, hresp;
   logic [1:0]  htrans;
   logic [2:0]  hsize, hburst;
   logic [3:0]  hprot;
   logic [30:0] haddr;
   logic [31:0] hwdata, hrdata;

   int checks   = 0;
   int failures = 0;

   ahb_cmd_master #(.ADDR_W(31), .DATA_W(32), .RSP_DEPTH(4)) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error), .hmastlock(hmastlock), .htrans(htrans),
      .hsize(hsize), .hburst(hburst), .hwrite(hwrite), .hprot(hprot),
      .haddr(haddr), .hwdata(hwdata), .hready(hready), .hresp(hresp),
      .hrdata(hrdata)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic wr, input logic [2:0] sz,
                                input logic [30:0] a, input logic [31:0] wd,
                                input logic hrdy, input logic hrsp,
                                input logic [31:0] hrd, input logic rrdy);
      cmd_valid = v;
      cmd_write = wr;
      cmd_size  = sz;
      cmd_addr  = a;
      cmd_wdata = wd;
      hready    = hrdy;
      hresp     = hrsp;
      hrdata    = hrd;
      rsp_ready = rrdy;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0;
      applyStimulus(0, 0, 2, 0, 0, 1, 0, 0, 1);
      repeat (2) @(posedge clock);
      #1;
      // Reset state
      checkOutput("rst_htrans", 64'(htrans), 64'd0);
      checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("rst_haddr", 64'(haddr), 64'd0);
      checkOutput("rst_hwdata", 64'(hwdata), 64'd0);
      checkOutput("rst_hprot", 64'(hprot), 64'h3);
      checkOutput("rst_hburst", 64'(hburst), 64'd0);
      checkOutput("rst_hmastlock", 64'(hmastlock), 64'd0);
      reset = 1'b1;
      $display("[TB] reset released");

      // Write 0x100 then read 0x100, zero wait
      tick(); applyStimulus(1, 1, 2, 31'h100, 32'hDEADBEEF, 1, 0, 0, 1);
      checkOutput("t1_c0_ready", 64'(cmd_ready), 64'd1);
      checkOutput("t1_c0_htrans", 64'(htrans), 64'd0);
      tick(); applyStimulus(1, 0, 2, 31'h100, 0, 1, 0, 0, 1);
      checkOutput("t1_c1_htrans", 64'(htrans), 64'd2);
      checkOutput("t1_c1_haddr", 64'(haddr), 64'h100);
      checkOutput("t1_c1_hwrite", 64'(hwrite), 64'd1);
      checkOutput("t1_c1_hsize", 64'(hsize), 64'd2);
      checkOutput("t1_c1_ready", 64'(cmd_ready), 64'd1);
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 32'h12345678, 1);
      checkOutput("t1_c2_htrans", 64'(htrans), 64'd2);
      checkOutput("t1_c2_hwrite", 64'(hwrite), 64'd0);
      checkOutput("t1_c2_hwdata", 64'(hwdata), 64'hDEADBEEF);
      checkOutput("t1_c2_rsp_valid", 64'(rsp_valid), 64'd0);
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 32'hDEADBEEF, 1);
      checkOutput("t1_c3_htrans", 64'(htrans), 64'd0);
      checkOutput("t1_c3_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("t1_c3_rsp_rdata", 64'(rsp_rdata), 64'd0);
      checkOutput("t1_c3_rsp_error", 64'(rsp_error), 64'd0);
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 0, 1);
      checkOutput("t1_c4_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("t1_c4_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
      checkOutput("t1_c4_rsp_error", 64'(rsp_error), 64'd0);
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 0, 1);
      checkOutput("t1_c5_rsp_valid", 64'(rsp_valid), 64'd0);

      // Eight back-to-back reads
      for (int k = 0; k < 12; k++) begin
         tick();
         applyStimulus(k < 8, 0, 2, 31'(32'h40 + 4 * k), 0, 1, 0,
                       32'(32'hA0000000 + k - 2), 1);
         if (k >= 1 && k <= 8) begin
            checkOutput($sformatf("t2_htrans_%0d", k), 64'(htrans), 64'd2);
            checkOutput($sformatf("t2_haddr_%0d", k), 64'(haddr), 64'(32'h40 + 4 * (k - 1)));
         end else begin
            checkOutput($sformatf("t2_htrans_%0d", k), 64'(htrans), 64'd0);
         end
         if (k < 8) checkOutput($sformatf("t2_ready_%0d", k), 64'(cmd_ready), 64'd1);
         if (k >= 3 && k <= 10) begin
            checkOutput($sformatf("t2_rsp_valid_%0d", k), 64'(rsp_valid), 64'd1);
            checkOutput($sformatf("t2_rsp_rdata_%0d", k), 64'(rsp_rdata), 64'(32'hA0000000 + k - 3));
         end else begin
            checkOutput($sformatf("t2_rsp_valid_%0d", k), 64'(rsp_valid), 64'd0);
         end
      end

      // Read 0x300 with three wait states while read 0x304 waits in the address phase
      tick(); applyStimulus(1, 0, 2, 31'h300, 32'h0A0A0A0A, 1, 0, 0, 1);
      tick(); applyStimulus(1, 0, 2, 31'h304, 32'h0B0B0B0B, 1, 0, 0, 1);
      checkOutput("t3_c1_haddr", 64'(haddr), 64'h300);
      checkOutput("t3_c1_ready", 64'(cmd_ready), 64'd1);
      for (int w = 0; w < 3; w++) begin
         tick(); applyStimulus(0, 0, 2, 0, 0, 0, 0, 32'hFFFFFFFF, 1);
         checkOutput($sformatf("t3_wait%0d_htrans", w), 64'(htrans), 64'd2);
         checkOutput($sformatf("t3_wait%0d_haddr", w), 64'(haddr), 64'h304);
         checkOutput($sformatf("t3_wait%0d_hwdata", w), 64'(hwdata), 64'h0A0A0A0A);
         checkOutput($sformatf("t3_wait%0d_rsp_valid", w), 64'(rsp_valid), 64'd0);
      end
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 32'hCAFE0001, 1);
      checkOutput("t3_c5_htrans", 64'(htrans), 64'd2);
      checkOutput("t3_c5_haddr", 64'(haddr), 64'h304);
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 32'hCAFE0002, 1);
      checkOutput("t3_c6_htrans", 64'(htrans), 64'd0);
      checkOutput("t3_c6_hwdata", 64'(hwdata), 64'h0B0B0B0B);
      checkOutput("t3_c6_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("t3_c6_rsp_rdata", 64'(rsp_rdata), 64'hCAFE0001);
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 0, 1);
      checkOutput("t3_c7_rsp_rdata", 64'(rsp_rdata), 64'hCAFE0002);
      checkOutput("t3_c7_rsp_valid", 64'(rsp_valid), 64'd1);
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 0, 1);
      checkOutput("t3_c8_rsp_valid", 64'(rsp_valid), 64'd0);

      // ERROR on write 0x200 while read 0x204 sits in the address phase
      tick(); applyStimulus(1, 1, 2, 31'h200, 32'h11112222, 1, 0, 0, 1);
      tick(); applyStimulus(1, 0, 2, 31'h204, 0, 1, 0, 0, 1);
      checkOutput("t4_c1_haddr", 64'(haddr), 64'h200);
      tick(); applyStimulus(0, 0, 2, 0, 0, 0, 1, 0, 1);
      checkOutput("t4_c2_htrans", 64'(htrans), 64'd2);
      checkOutput("t4_c2_haddr", 64'(haddr), 64'h204);
      checkOutput("t4_c2_ready", 64'(cmd_ready), 64'd0);
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 1, 0, 1);
      checkOutput("t4_c3_htrans", 64'(htrans), 64'd0);
      checkOutput("t4_c3_ready", 64'(cmd_ready), 64'd0);
      checkOutput("t4_c3_rsp_valid", 64'(rsp_valid), 64'd0);
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 0, 1);
      checkOutput("t4_c4_htrans", 64'(htrans), 64'd2);
      checkOutput("t4_c4_haddr", 64'(haddr), 64'h204);
      checkOutput("t4_c4_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("t4_c4_rsp_error", 64'(rsp_error), 64'd1);
      checkOutput("t4_c4_rsp_rdata", 64'(rsp_rdata), 64'd0);
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 32'h77778888, 1);
      checkOutput("t4_c5_htrans", 64'(htrans), 64'd0);
      checkOutput("t4_c5_rsp_valid", 64'(rsp_valid), 64'd0);
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 0, 1);
      checkOutput("t4_c6_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("t4_c6_rsp_rdata", 64'(rsp_rdata), 64'h77778888);
      checkOutput("t4_c6_rsp_error", 64'(rsp_error), 64'd0);
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 0, 1);
      checkOutput("t4_c7_rsp_valid", 64'(rsp_valid), 64'd0);

      // Local rejects: misaligned 0x102 size 2, then size 3 on a 32-bit bus
      tick(); applyStimulus(1, 0, 2, 31'h102, 0, 1, 0, 0, 1);
      checkOutput("t5_c0_ready", 64'(cmd_ready), 64'd1);
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 0, 1);
      checkOutput("t5_c1_htrans", 64'(htrans), 64'd0);
      checkOutput("t5_c1_rsp_valid", 64'(rsp_valid), 64'd0);
      tick(); applyStimulus(1, 0, 3, 31'h100, 0, 1, 0, 0, 1);
      checkOutput("t5_c2_htrans", 64'(htrans), 64'd0);
      checkOutput("t5_c2_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("t5_c2_rsp_error", 64'(rsp_error), 64'd1);
      checkOutput("t5_c2_rsp_rdata", 64'(rsp_rdata), 64'd0);
      checkOutput("t5_c2_ready", 64'(cmd_ready), 64'd1);
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 0, 1);
      checkOutput("t5_c3_htrans", 64'(htrans), 64'd0);
      checkOutput("t5_c3_rsp_valid", 64'(rsp_valid), 64'd0);
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 0, 1);
      checkOutput("t5_c4_htrans", 64'(htrans), 64'd0);
      checkOutput("t5_c4_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("t5_c4_rsp_error", 64'(rsp_error), 64'd1);
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 0, 1);
      checkOutput("t5_c5_rsp_valid", 64'(rsp_valid), 64'd0);

      // Credit limit: rsp_ready low, six reads offered, only four fit
      tick(); applyStimulus(1, 0, 2, 31'h500, 0, 1, 0, 0, 0);
      checkOutput("t6_c0_ready", 64'(cmd_ready), 64'd1);
      tick(); applyStimulus(1, 0, 2, 31'h504, 0, 1, 0, 0, 0);
      checkOutput("t6_c1_ready", 64'(cmd_ready), 64'd1);
      tick(); applyStimulus(1, 0, 2, 31'h508, 0, 1, 0, 32'hB0000000, 0);
      checkOutput("t6_c2_ready", 64'(cmd_ready), 64'd1);
      tick(); applyStimulus(1, 0, 2, 31'h50C, 0, 1, 0, 32'hB0000001, 0);
      checkOutput("t6_c3_ready", 64'(cmd_ready), 64'd1);
      tick(); applyStimulus(1, 0, 2, 31'h510, 0, 1, 0, 32'hB0000002, 0);
      checkOutput("t6_c4_ready", 64'(cmd_ready), 64'd0);
      tick(); applyStimulus(1, 0, 2, 31'h510, 0, 1, 0, 32'hB0000003, 0);
      checkOutput("t6_c5_ready", 64'(cmd_ready), 64'd0);
      tick(); applyStimulus(1, 0, 2, 31'h510, 0, 1, 0, 0, 0);
      checkOutput("t6_c6_ready", 64'(cmd_ready), 64'd0);
      checkOutput("t6_c6_htrans", 64'(htrans), 64'd0);
      tick(); applyStimulus(1, 0, 2, 31'h510, 0, 1, 0, 0, 1);
      checkOutput("t6_c7_ready", 64'(cmd_ready), 64'd0);
      checkOutput("t6_c7_rsp_rdata", 64'(rsp_rdata), 64'hB0000000);
      tick(); applyStimulus(1, 0, 2, 31'h510, 0, 1, 0, 0, 1);
      checkOutput("t6_c8_ready", 64'(cmd_ready), 64'd1);
      checkOutput("t6_c8_rsp_rdata", 64'(rsp_rdata), 64'hB0000001);
      tick(); applyStimulus(1, 0, 2, 31'h514, 0, 1, 0, 0, 1);
      checkOutput("t6_c9_ready", 64'(cmd_ready), 64'd1);
      checkOutput("t6_c9_haddr", 64'(haddr), 64'h510);
      checkOutput("t6_c9_rsp_rdata", 64'(rsp_rdata), 64'hB0000002);
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 32'hB0000004, 1);
      checkOutput("t6_c10_haddr", 64'(haddr), 64'h514);
      checkOutput("t6_c10_rsp_rdata", 64'(rsp_rdata), 64'hB0000003);
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 32'hB0000005, 1);
      checkOutput("t6_c11_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("t6_c11_rsp_rdata", 64'(rsp_rdata), 64'hB0000004);
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 0, 1);
      checkOutput("t6_c12_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("t6_c12_rsp_rdata", 64'(rsp_rdata), 64'hB0000005);
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 0, 1);
      checkOutput("t6_c13_rsp_valid", 64'(rsp_valid), 64'd0);

      // Reset asserted mid-burst
      tick(); applyStimulus(1, 0, 2, 31'h600, 0, 1, 0, 0, 0);
      tick(); applyStimulus(1, 0, 2, 31'h604, 0, 1, 0, 0, 0);
      tick(); applyStimulus(1, 0, 2, 31'h608, 0, 1, 0, 32'h600D0000, 0);
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 0, 0);
      checkOutput("t7_pre_htrans", 64'(htrans), 64'd2);
      checkOutput("t7_pre_rsp_valid", 64'(rsp_valid), 64'd1);
      reset = 1'b0;
      #1;
      checkOutput("t7_rst_htrans", 64'(htrans), 64'd0);
      checkOutput("t7_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("t7_rst_ready", 64'(cmd_ready), 64'd0);
      tick();
      reset = 1'b1;
      tick(); applyStimulus(0, 0, 2, 0, 0, 1, 0, 0, 1);
      checkOutput("t7_post_htrans", 64'(htrans), 64'd0);
      checkOutput("t7_post_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("t7_post_ready", 64'(cmd_ready), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
